// File: rtl/adc_pkg.sv
// Shared definitions for the LTC2308 responder.
//   state_t    : responder FSM states
//   ADC_*      : sample and config word widths
//   CFG_*      : bit positions inside the 6-bit config word {S/D,O/S,S1,S0,UNI,SLP}
//   CFG_RESET  : config in force after reset (single-ended, ch0, unipolar)
//   cfg_chan() : channel index {S1,S0,O/S} decoded from a config word
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        READY = 2'd2,
        SHIFT = 2'd3
    } state_t;

    localparam int unsigned ADC_DATA_W = 12;
    localparam int unsigned ADC_CFG_W  = 6;

    localparam int unsigned CFG_SD  = 5;
    localparam int unsigned CFG_OS  = 4;
    localparam int unsigned CFG_S1  = 3;
    localparam int unsigned CFG_S0  = 2;
    localparam int unsigned CFG_UNI = 1;
    localparam int unsigned CFG_SLP = 0;

    localparam logic [ADC_CFG_W-1:0] CFG_RESET = 6'b100010;

    function automatic logic [2:0] cfg_chan(input logic [ADC_CFG_W-1:0] cfg);
        return {cfg[CFG_S1], cfg[CFG_S0], cfg[CFG_OS]};
    endfunction

endpackage

// File: rtl/sig_sync_edge.sv
// Input synchronizer followed by a rise/fall edge detector.
// Build option: ADC_RESP_SYNC2_EN selects a 2-flop synchronizer; otherwise a single
// register stage is used (only safe when d_i is already synchronous to clk).
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   d_i          : raw input pin
//   level_o      : synchronized level
//   rise_o       : 1-clk strobe on a synchronized 0->1 transition
//   fall_o       : 1-clk strobe on a synchronized 1->0 transition
module sig_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

`ifdef ADC_RESP_SYNC2_EN
    logic meta_q, meta_d;
`endif
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
`ifdef ADC_RESP_SYNC2_EN
        meta_d = d_i;
        sync_d = meta_q;
`else
        sync_d = d_i;
`endif
        prev_d = sync_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
`ifdef ADC_RESP_SYNC2_EN
            meta_q <= 1'b0;
`endif
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
`ifdef ADC_RESP_SYNC2_EN
            meta_q <= meta_d;
`endif
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
    assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/ltc2308_responder.sv
// Target-side model of the LTC2308 ADC serial link.
// CONVST starts a conversion of the channel selected by the config in force; after
// CONV_CYCLES the sample is shifted out MSB first on ADC_SDO (new bit per SCK fall) while
// the config word is shifted in from ADC_SDI (one bit per SCK rise).
// Build option: ADC_RESP_SYNC2_EN selects 2-flop input synchronizers (see sig_sync_edge).
// Ports:
//   clk, reset_n          : responder clock (>= 4x SCK) and asynchronous active-low reset
//   ADC_CONVST/SCK/SDI    : link inputs from the initiator
//   ADC_SDO               : sample bits to the initiator
//   chan_data             : unipolar value per channel, ch n = [n*DATA_W +: DATA_W]
//   cfg_word              : last complete config word
//   frame_done, frame_err : 1-clk pulses for frame completion and protocol violations
module ltc2308_responder
    import adc_pkg::*;
#(
    parameter int unsigned DATA_W      = ADC_DATA_W,
    parameter int unsigned NUM_CH      = 8,
    parameter int unsigned CONV_CYCLES = 80
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     ADC_CONVST,
    input  logic                     ADC_SCK,
    input  logic                     ADC_SDI,
    output logic                     ADC_SDO,
    input  logic [NUM_CH*DATA_W-1:0] chan_data,
    output logic [ADC_CFG_W-1:0]     cfg_word,
    output logic                     frame_done,
    output logic                     frame_err
);

    localparam int unsigned CNT_W = $clog2(CONV_CYCLES + 1);

    logic conv_lvl, conv_rise, conv_fall;
    logic sck_lvl, sck_rise, sck_fall;
    logic sdi_lvl, sdi_rise, sdi_fall;

    sig_sync_edge u_sync_convst (
        .clk    (clk),
        .reset_n(reset_n),
        .d_i    (ADC_CONVST),
        .level_o(conv_lvl),
        .rise_o (conv_rise),
        .fall_o (conv_fall)
    );

    sig_sync_edge u_sync_sck (
        .clk    (clk),
        .reset_n(reset_n),
        .d_i    (ADC_SCK),
        .level_o(sck_lvl),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    sig_sync_edge u_sync_sdi (
        .clk    (clk),
        .reset_n(reset_n),
        .d_i    (ADC_SDI),
        .level_o(sdi_lvl),
        .rise_o (sdi_rise),
        .fall_o (sdi_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{conv_lvl, conv_fall, sck_lvl, sdi_rise, sdi_fall};

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     conv_cnt_q, conv_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [ADC_CFG_W-1:0] cfg_shift_q, cfg_shift_d;
    logic [ADC_CFG_W-1:0] cfg_q, cfg_d;
    logic [DATA_W-1:0]    sample_q, sample_d;
    logic                 sdo_q, sdo_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    // Sample for the channel selected by the config in force right now; unipolar off
    // means flip the MSB to turn straight binary into two's complement.
    logic [2:0]        ch_sel;
    logic [DATA_W-1:0] raw_sel, snap;

    always_comb begin
        ch_sel  = cfg_chan(cfg_q);
        raw_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == 3'(i)) begin
                raw_sel = chan_data[i*DATA_W +: DATA_W];
            end
        end
        snap = cfg_q[CFG_UNI] ? raw_sel : (raw_sel ^ {1'b1, {(DATA_W-1){1'b0}}});
    end

    always_comb begin
        state_d     = state_q;
        conv_cnt_d  = conv_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        cfg_shift_d = cfg_shift_q;
        cfg_d       = cfg_q;
        sample_d    = sample_q;
        sdo_d       = sdo_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                sdo_d = 1'b0;
                if (conv_rise) begin
                    state_d     = CONV;
                    sample_d    = snap;
                    conv_cnt_d  = CNT_W'(CONV_CYCLES - 1);
                    bit_cnt_d   = '0;
                    cfg_shift_d = '0;
                end else if (sck_rise || sck_fall) begin
                    err_d = 1'b1;
                end
            end
            CONV: begin
                // Stray CONVST or SCK edges are flagged but never disturb the conversion.
                err_d = conv_rise | sck_rise | sck_fall;
                if (conv_cnt_q == '0) begin
                    state_d = READY;
                    sdo_d   = sample_q[DATA_W-1];
                end else begin
                    conv_cnt_d = conv_cnt_q - CNT_W'(1);
                end
            end
            READY, SHIFT: begin
                if (conv_rise) begin
                    // Abort: config being shifted in is dropped, cfg_q stays as it was.
                    err_d       = 1'b1;
                    state_d     = CONV;
                    sample_d    = snap;
                    conv_cnt_d  = CNT_W'(CONV_CYCLES - 1);
                    bit_cnt_d   = '0;
                    cfg_shift_d = '0;
                    sdo_d       = 1'b0;
                end else if (sck_rise) begin
                    state_d   = SHIFT;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q < 4'(ADC_CFG_W)) begin
                        cfg_shift_d = {cfg_shift_q[ADC_CFG_W-2:0], sdi_lvl};
                    end
                end else if (sck_fall && state_q == SHIFT) begin
                    if (bit_cnt_q == 4'(DATA_W)) begin
                        state_d   = IDLE;
                        sdo_d     = 1'b0;
                        done_d    = 1'b1;
                        cfg_d     = cfg_shift_q;
                        bit_cnt_d = '0;
                    end else begin
                        sample_d = {sample_q[DATA_W-2:0], 1'b0};
                        sdo_d    = sample_q[DATA_W-2];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            conv_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            cfg_shift_q <= '0;
            cfg_q       <= CFG_RESET;
            sample_q    <= '0;
            sdo_q       <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            conv_cnt_q  <= conv_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            cfg_shift_q <= cfg_shift_d;
            cfg_q       <= cfg_d;
            sample_q    <= sample_d;
            sdo_q       <= sdo_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign ADC_SDO    = sdo_q;
    assign cfg_word   = cfg_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule
